// File: rtl/ysyx_22041071_decode_queue_pkg.sv
// ysyx_22041071_decode_queue_pkg
//   Shared decode constants for the decode queue: RV opcodes, ALU op codes
//   (0-30 live, 31 = none/illegal), operand-select codes, out_ctl bit positions.
//   Optional feature macro used by the decoder: YSYX_22041071_RV_M_EN.
package ysyx_22041071_decode_queue_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

   // BLT/BLTU reuse SLT/SLTU. MULHSU has no code and decodes as illegal.
   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLL   = 5'd2,  ALU_SLT   = 5'd3,
      ALU_SLTU  = 5'd4,  ALU_XOR   = 5'd5,  ALU_SRL   = 5'd6,  ALU_SRA   = 5'd7,
      ALU_OR    = 5'd8,  ALU_AND   = 5'd9,  ALU_ADDW  = 5'd10, ALU_SUBW  = 5'd11,
      ALU_SLLW  = 5'd12, ALU_SRLW  = 5'd13, ALU_SRAW  = 5'd14, ALU_EQ    = 5'd15,
      ALU_NE    = 5'd16, ALU_GE    = 5'd17, ALU_GEU   = 5'd18, ALU_MUL   = 5'd19,
      ALU_MULH  = 5'd20, ALU_MULHU = 5'd21, ALU_DIV   = 5'd22, ALU_DIVU  = 5'd23,
      ALU_REM   = 5'd24, ALU_REMU  = 5'd25, ALU_MULW  = 5'd26, ALU_DIVW  = 5'd27,
      ALU_DIVUW = 5'd28, ALU_REMW  = 5'd29, ALU_REMUW = 5'd30, ALU_NONE  = 5'd31
   } alu_op_e;

   typedef enum logic [2:0] {SRC1_RS1 = 3'd0, SRC1_ZERO = 3'd4, SRC1_PC = 3'd5} src1_e;
   typedef enum logic [2:0] {SRC2_RS2 = 3'd0, SRC2_IMM = 3'd1, SRC2_FOUR = 3'd5} src2_e;

   // out_ctl = {jalr, branch, mem_w, wb_mem, reg_w, illegal}
   localparam int CTL_ILLEGAL = 0;
   localparam int CTL_REG_W   = 1;
   localparam int CTL_WB_MEM  = 2;
   localparam int CTL_MEM_W   = 3;
   localparam int CTL_BRANCH  = 4;
   localparam int CTL_JALR    = 5;

   // Control-flow opcodes that squash the IF register.
   function automatic logic is_flow_opc(input logic [6:0] opc);
      return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/ysyx_22041071_decode_queue_if.sv
// ysyx_22041071_decode_queue_if
//   IF->ID / ID->EX handshake bundle of the decode queue.
//   slave  : the decode queue (accepts in_*, flush, out_ready; drives the rest)
//   master : the surrounding pipeline (IF/EX side)
//   Parameters XLEN / DEPTH must match the attached decode queue.
interface ysyx_22041071_decode_queue_if #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_pc;
   logic [31:0]      in_ins;
   logic             jal_redir;
   logic [XLEN-1:0]  jal_pc;
   logic             bubble;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [31:0]      out_ins;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_src1;
   logic [2:0]       out_src2;
   logic [4:0]       out_alu;
   logic [5:0]       out_ctl;
   logic [CNT_W-1:0] count;

   modport slave (
      input  flush, in_valid, in_pc, in_ins, out_ready,
      output in_ready, jal_redir, jal_pc, bubble, out_valid, out_pc, out_ins,
             out_rs1, out_rs2, out_rd, out_imm, out_src1, out_src2, out_alu,
             out_ctl, count
   );

   modport master (
      output flush, in_valid, in_pc, in_ins, out_ready,
      input  in_ready, jal_redir, jal_pc, bubble, out_valid, out_pc, out_ins,
             out_rs1, out_rs2, out_rd, out_imm, out_src1, out_src2, out_alu,
             out_ctl, count
   );
endinterface

// File: rtl/ysyx_22041071_decode_queue_dec_core.sv
// ysyx_22041071_dec_core
//   Pure combinational RV instruction -> decoded bundle.
//   ins     in  32    instruction word
//   imm     out XLEN  selected immediate, sign-extended
//   rs1/rs2/rd out 5  register indices (raw fields)
//   src1/src2 out 3   operand selects; alu out 5; ctl out 6
//   is_jal / is_flow  legal JAL / legal JAL-JALR-Bxx
//   Macro YSYX_22041071_RV_M_EN enables mul/div/rem decoding.
module ysyx_22041071_dec_core
   import ysyx_22041071_decode_queue_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     ins,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      src1,
   output logic [2:0]      src2,
   output logic [4:0]      alu,
   output logic [5:0]      ctl,
   output logic            is_jal,
   output logic            is_flow
);
   localparam bit RV64 = (XLEN == 64);

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
   logic        shamt_ok;
   alu_op_e     alu_v;
   src1_e       s1;
   src2_e       s2;
   logic        legal, jalr_v, branch_v, mem_w_v, wb_mem_v, reg_w_v;

   assign opc = ins[6:0];
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];
   assign rs1 = ins[19:15];
   assign rs2 = ins[24:20];
   assign rd  = ins[11:7];

   assign imm_i = {{20{ins[31]}}, ins[31:20]};
   assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {ins[31:12], 12'b0};
   assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

   // RV32 shifts only have a 5-bit shamt, so ins[25] must be clear.
   assign shamt_ok = RV64 || !ins[25];

   always_comb begin
      alu_v    = ALU_ADD;
      s1       = SRC1_RS1;
      s2       = SRC2_RS2;
      imm32    = '0;
      legal    = 1'b0;
      jalr_v   = 1'b0;
      branch_v = 1'b0;
      mem_w_v  = 1'b0;
      wb_mem_v = 1'b0;
      reg_w_v  = 1'b0;
      case (opc)
         OPC_LUI: begin
            legal = 1'b1; reg_w_v = 1'b1; s1 = SRC1_ZERO; s2 = SRC2_IMM; imm32 = imm_u;
         end
         OPC_AUIPC: begin
            legal = 1'b1; reg_w_v = 1'b1; s1 = SRC1_PC; s2 = SRC2_IMM; imm32 = imm_u;
         end
         OPC_JAL: begin
            legal = 1'b1; reg_w_v = 1'b1; s1 = SRC1_PC; s2 = SRC2_FOUR; imm32 = imm_j;
         end
         OPC_JALR: begin
            legal = (f3 == 3'b000); reg_w_v = 1'b1; jalr_v = 1'b1;
            s1 = SRC1_PC; s2 = SRC2_FOUR; imm32 = imm_i;
         end
         OPC_BRANCH: begin
            legal = 1'b1; branch_v = 1'b1; imm32 = imm_b;
            case (f3)
               3'b000:  alu_v = ALU_EQ;
               3'b001:  alu_v = ALU_NE;
               3'b100:  alu_v = ALU_SLT;
               3'b101:  alu_v = ALU_GE;
               3'b110:  alu_v = ALU_SLTU;
               3'b111:  alu_v = ALU_GEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            reg_w_v = 1'b1; wb_mem_v = 1'b1; s2 = SRC2_IMM; imm32 = imm_i;
            case (f3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
               3'b011, 3'b110:                         legal = RV64;
               default:                                legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            mem_w_v = 1'b1; s2 = SRC2_IMM; imm32 = imm_s;
            case (f3)
               3'b000, 3'b001, 3'b010: legal = 1'b1;
               3'b011:                 legal = RV64;
               default:                legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            legal = 1'b1; reg_w_v = 1'b1; s2 = SRC2_IMM; imm32 = imm_i;
            case (f3)
               3'b000: alu_v = ALU_ADD;
               3'b010: alu_v = ALU_SLT;
               3'b011: alu_v = ALU_SLTU;
               3'b100: alu_v = ALU_XOR;
               3'b110: alu_v = ALU_OR;
               3'b111: alu_v = ALU_AND;
               3'b001: begin
                  alu_v = ALU_SLL;
                  legal = (ins[31:26] == 6'b0) && shamt_ok;
               end
               default: begin
                  if (ins[30]) alu_v = ALU_SRA;
                  else         alu_v = ALU_SRL;
                  legal = ({ins[31], ins[29:26]} == 5'b0) && shamt_ok;
               end
            endcase
         end
         OPC_OP: begin
            reg_w_v = 1'b1;
            if (f7 == 7'b0000000) begin
               legal = 1'b1;
               case (f3)
                  3'b000:  alu_v = ALU_ADD;
                  3'b001:  alu_v = ALU_SLL;
                  3'b010:  alu_v = ALU_SLT;
                  3'b011:  alu_v = ALU_SLTU;
                  3'b100:  alu_v = ALU_XOR;
                  3'b101:  alu_v = ALU_SRL;
                  3'b110:  alu_v = ALU_OR;
                  default: alu_v = ALU_AND;
               endcase
            end else if (f7 == 7'b0100000) begin
               case (f3)
                  3'b000:  begin alu_v = ALU_SUB; legal = 1'b1; end
                  3'b101:  begin alu_v = ALU_SRA; legal = 1'b1; end
                  default: legal = 1'b0;
               endcase
            end else if (f7 == 7'b0000001) begin
`ifdef YSYX_22041071_RV_M_EN
               legal = 1'b1;
               case (f3)
                  3'b000:  alu_v = ALU_MUL;
                  3'b001:  alu_v = ALU_MULH;
                  3'b011:  alu_v = ALU_MULHU;
                  3'b100:  alu_v = ALU_DIV;
                  3'b101:  alu_v = ALU_DIVU;
                  3'b110:  alu_v = ALU_REM;
                  3'b111:  alu_v = ALU_REMU;
                  default: legal = 1'b0;
               endcase
`else
               legal = 1'b0;
`endif
            end
         end
         OPC_OP_IMM32: begin
            reg_w_v = 1'b1; s2 = SRC2_IMM; imm32 = imm_i;
            case (f3)
               3'b000: begin alu_v = ALU_ADDW; legal = RV64; end
               3'b001: begin alu_v = ALU_SLLW; legal = RV64 && (f7 == 7'b0000000); end
               3'b101: begin
                  if (f7 == 7'b0100000) alu_v = ALU_SRAW;
                  else                  alu_v = ALU_SRLW;
                  legal = RV64 && ((f7 == 7'b0000000) || (f7 == 7'b0100000));
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_OP32: begin
            reg_w_v = 1'b1;
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  begin alu_v = ALU_ADDW; legal = RV64; end
                  3'b001:  begin alu_v = ALU_SLLW; legal = RV64; end
                  3'b101:  begin alu_v = ALU_SRLW; legal = RV64; end
                  default: legal = 1'b0;
               endcase
            end else if (f7 == 7'b0100000) begin
               case (f3)
                  3'b000:  begin alu_v = ALU_SUBW; legal = RV64; end
                  3'b101:  begin alu_v = ALU_SRAW; legal = RV64; end
                  default: legal = 1'b0;
               endcase
            end else if (f7 == 7'b0000001) begin
`ifdef YSYX_22041071_RV_M_EN
               case (f3)
                  3'b000:  begin alu_v = ALU_MULW;  legal = RV64; end
                  3'b100:  begin alu_v = ALU_DIVW;  legal = RV64; end
                  3'b101:  begin alu_v = ALU_DIVUW; legal = RV64; end
                  3'b110:  begin alu_v = ALU_REMW;  legal = RV64; end
                  3'b111:  begin alu_v = ALU_REMUW; legal = RV64; end
                  default: legal = 1'b0;
               endcase
`else
               legal = 1'b0;
`endif
            end
         end
         default: legal = 1'b0;
      endcase
      // Illegal entries still flow to EX, but must not write anything.
      if (!legal) begin
         alu_v    = ALU_NONE;
         s1       = SRC1_RS1;
         s2       = SRC2_RS2;
         imm32    = '0;
         jalr_v   = 1'b0;
         branch_v = 1'b0;
         mem_w_v  = 1'b0;
         wb_mem_v = 1'b0;
         reg_w_v  = 1'b0;
      end
   end

   always_comb begin
      ctl              = '0;
      ctl[CTL_JALR]    = jalr_v;
      ctl[CTL_BRANCH]  = branch_v;
      ctl[CTL_MEM_W]   = mem_w_v;
      ctl[CTL_WB_MEM]  = wb_mem_v;
      ctl[CTL_REG_W]   = reg_w_v;
      ctl[CTL_ILLEGAL] = ~legal;
   end

   assign imm     = XLEN'($signed(imm32));
   assign alu     = alu_v;
   assign src1    = s1;
   assign src2    = s2;
   assign is_jal  = legal && (opc == OPC_JAL);
   assign is_flow = legal && is_flow_opc(opc);

endmodule

// File: rtl/ysyx_22041071_decode_queue.sv
// ysyx_22041071_decode_queue
//   RV decode stage: decodes IF->ID instructions and buffers the decoded
//   bundles in a DEPTH-entry FIFO toward EX, valid/ready on both sides.
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   q        slave modport: flush, in_* handshake, jal_redir/jal_pc/bubble,
//            out_* head bundle with out_valid/out_ready, count occupancy
//   Macro YSYX_22041071_RV_M_EN (decoder) enables mul/div/rem.
module ysyx_22041071_decode_queue
   import ysyx_22041071_decode_queue_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input logic                     clk,
   input logic                     reset_n,
   ysyx_22041071_decode_queue_if.slave q
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     ins;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [2:0]      src1;
      logic [2:0]      src2;
      logic [4:0]      alu;
      logic [5:0]      ctl;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           dec_e, head_e;
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             full, empty, enq, deq;

   logic [XLEN-1:0]  d_imm;
   logic [4:0]       d_rs1, d_rs2, d_rd, d_alu;
   logic [2:0]       d_src1, d_src2;
   logic [5:0]       d_ctl;
   logic             d_jal, d_flow;

   ysyx_22041071_dec_core #(.XLEN(XLEN)) u_dec (
      .ins     (q.in_ins),
      .imm     (d_imm),
      .rs1     (d_rs1),
      .rs2     (d_rs2),
      .rd      (d_rd),
      .src1    (d_src1),
      .src2    (d_src2),
      .alu     (d_alu),
      .ctl     (d_ctl),
      .is_jal  (d_jal),
      .is_flow (d_flow)
   );

   always_comb begin
      dec_e      = '0;
      dec_e.pc   = q.in_pc;
      dec_e.ins  = q.in_ins;
      dec_e.rs1  = d_rs1;
      dec_e.rs2  = d_rs2;
      dec_e.rd   = d_rd;
      dec_e.imm  = d_imm;
      dec_e.src1 = d_src1;
      dec_e.src2 = d_src2;
      dec_e.alu  = d_alu;
      dec_e.ctl  = d_ctl;
   end

   // No full bypass: a pop in the same cycle does not free the slot early.
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign enq   = q.in_valid && !full && !q.flush;
   assign deq   = !empty && q.out_ready && !q.flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (q.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            mem[tail] <= dec_e;
            tail      <= tail + 1'b1;
         end
         if (deq) head <= head + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_e      = mem[head];
   assign q.in_ready  = !full;
   assign q.out_valid = !empty;
   assign q.count     = count;
   assign q.out_pc    = head_e.pc;
   assign q.out_ins   = head_e.ins;
   assign q.out_rs1   = head_e.rs1;
   assign q.out_rs2   = head_e.rs2;
   assign q.out_rd    = head_e.rd;
   assign q.out_imm   = head_e.imm;
   assign q.out_src1  = head_e.src1;
   assign q.out_src2  = head_e.src2;
   assign q.out_alu   = head_e.alu;
   assign q.out_ctl   = head_e.ctl;

   assign q.jal_redir = enq && d_jal;
   assign q.bubble    = enq && d_flow;
   assign q.jal_pc    = q.jal_redir ? (q.in_pc + d_imm) : '0;

endmodule

// File: tb/tb_ysyx_22041071_decode_queue.sv
// tb_ysyx_22041071_decode_queue
//   Directed decode/handshake checks followed by random enq/deq/flush traffic
//   against a queue-based reference, with an asynchronous reset mid-run.
module tb_ysyx_22041071_decode_queue;
   localparam int XLEN  = 64;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ysyx_22041071_decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   ysyx_22041071_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .q       (bus)
   );

   typedef struct {
      logic [31:0] ins;
      logic [4:0]  alu;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [63:0] imm;
      logic [5:0]  ctl;
   } dvec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   dvec_t tbl [8];
   ent_t  mq [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] jimm(input logic [31:0] w);
      return {{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
   endfunction

   initial begin
      logic [31:0] w;
      logic [63:0] pc;
      logic        v, r, f, acc, pop, exp_redir, exp_bub;
      logic [6:0]  op;
      logic [2:0]  fn3;

      tbl[0] = '{32'h00500093, 5'd0,  3'd0, 3'd1, 64'd5,                  6'b000010}; // addi x1,x0,5
      tbl[1] = '{32'h402081B3, 5'd1,  3'd0, 3'd0, 64'd0,                  6'b000010}; // sub x3,x1,x2
      tbl[2] = '{32'h00812283, 5'd0,  3'd0, 3'd1, 64'd8,                  6'b000110}; // lw x5,8(x2)
      tbl[3] = '{32'hFE512E23, 5'd0,  3'd0, 3'd1, 64'hFFFFFFFFFFFFFFFC,   6'b001000}; // sw x5,-4(x2)
      tbl[4] = '{32'hFE208CE3, 5'd15, 3'd0, 3'd0, 64'hFFFFFFFFFFFFFFF8,   6'b010000}; // beq x1,x2,-8
      tbl[5] = '{32'h800003B7, 5'd0,  3'd4, 3'd1, 64'hFFFFFFFF80000000,   6'b000010}; // lui x7,0x80000
      tbl[6] = '{32'hFFFFFFFF, 5'd31, 3'd0, 3'd0, 64'd0,                  6'b000001}; // unlisted opcode
`ifdef YSYX_22041071_RV_M_EN
      tbl[7] = '{32'h022081B3, 5'd19, 3'd0, 3'd0, 64'd0,                  6'b000010}; // mul x3,x1,x2
`else
      tbl[7] = '{32'h022081B3, 5'd31, 3'd0, 3'd0, 64'd0,                  6'b000001}; // mul x3,x1,x2
`endif

      reset_n       = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_pc     = '0;
      bus.in_ins    = '0;
      bus.out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_count",     64'(bus.count), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_jal_redir", 64'(bus.jal_redir), 64'd0);
      chk("rst_bubble",    64'(bus.bubble), 64'd0);
      chk("rst_out_pc",    bus.out_pc, 64'd0);
      chk("rst_out_imm",   bus.out_imm, 64'd0);
      chk("rst_out_alu",   64'(bus.out_alu), 64'd0);
      chk("rst_out_ctl",   64'(bus.out_ctl), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Decode table: one instruction through an otherwise empty queue
      for (int k = 0; k < 8; k++) begin
         w             = tbl[k].ins;
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'b1;
         bus.in_pc     = 64'h1000 + 64'(4 * k);
         bus.in_ins    = w;
         step();
         bus.in_valid = 1'b0;
         chk("dec_count",     64'(bus.count), 64'd1);
         chk("dec_out_valid", 64'(bus.out_valid), 64'd1);
         chk("dec_out_pc",    bus.out_pc, 64'h1000 + 64'(4 * k));
         chk("dec_out_ins",   64'(bus.out_ins), 64'(w));
         chk("dec_alu",       64'(bus.out_alu), 64'(tbl[k].alu));
         chk("dec_src1",      64'(bus.out_src1), 64'(tbl[k].s1));
         chk("dec_src2",      64'(bus.out_src2), 64'(tbl[k].s2));
         chk("dec_imm",       bus.out_imm, tbl[k].imm);
         chk("dec_ctl",       64'(bus.out_ctl), 64'(tbl[k].ctl));
         chk("dec_rd",        64'(bus.out_rd), 64'(w[11:7]));
         chk("dec_rs1",       64'(bus.out_rs1), 64'(w[19:15]));
         chk("dec_rs2",       64'(bus.out_rs2), 64'(w[24:20]));
         bus.out_ready = 1'b1;
         step();
         chk("dec_drain_count", 64'(bus.count), 64'd0);
         chk("dec_drain_valid", 64'(bus.out_valid), 64'd0);
      end

      // Fill to DEPTH, third instruction held until a pop frees a slot
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 64'h100; bus.in_ins = tbl[0].ins; step();
      bus.in_pc     = 64'h104; bus.in_ins = tbl[1].ins; step();
      chk("full_count",    64'(bus.count), 64'd2);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_pc = 64'h108; bus.in_ins = tbl[2].ins;
      step();
      chk("held_count",  64'(bus.count), 64'd2);
      chk("held_out_pc", bus.out_pc, 64'h100);
      bus.out_ready = 1'b1;
      step();
      chk("pop_no_bypass_count", 64'(bus.count), 64'd1);
      chk("pop_out_pc",          bus.out_pc, 64'h104);
      chk("pop_in_ready",        64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b0;
      step();
      chk("third_in_count", 64'(bus.count), 64'd2);
      chk("third_head_pc",  bus.out_pc, 64'h104);

      // Flush while full with a valid input pending
      bus.flush = 1'b1;
      step();
      chk("flush_count", 64'(bus.count), 64'd0);
      chk("flush_valid", 64'(bus.out_valid), 64'd0);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      step();
      chk("flush_no_enq", 64'(bus.count), 64'd0);

      // JAL early redirect, first gated by flush
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 64'h80000000;
      bus.in_ins    = 32'h010000EF;
      bus.flush     = 1'b1;
      #1;
      chk("jal_flush_redir",  64'(bus.jal_redir), 64'd0);
      chk("jal_flush_bubble", 64'(bus.bubble), 64'd0);
      bus.flush = 1'b0;
      #1;
      chk("jal_redir",  64'(bus.jal_redir), 64'd1);
      chk("jal_bubble", 64'(bus.bubble), 64'd1);
      chk("jal_pc",     bus.jal_pc, 64'h80000010);
      step();
      bus.in_valid = 1'b0;
      chk("jal_out_alu",  64'(bus.out_alu), 64'd0);
      chk("jal_out_src1", 64'(bus.out_src1), 64'd5);
      chk("jal_out_src2", 64'(bus.out_src2), 64'd5);
      chk("jal_out_ctl",  64'(bus.out_ctl), 64'b000010);
      step();
      chk("jal_drain", 64'(bus.count), 64'd0);
      mq.delete();

      // Random traffic against the reference queue
      for (int c = 0; c < 10000; c++) begin
         chk("rnd_count",    64'(bus.count), 64'(mq.size()));
         chk("rnd_valid",    64'(bus.out_valid), 64'(mq.size() != 0));
         chk("rnd_in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
         if (mq.size() != 0) begin
            chk("rnd_out_pc",  bus.out_pc, mq[0].pc);
            chk("rnd_out_ins", 64'(bus.out_ins), 64'(mq[0].ins));
         end
         if (c == 5000) begin
            reset_n = 1'b0;
            #1;
            chk("midrst_count",    64'(bus.count), 64'd0);
            chk("midrst_valid",    64'(bus.out_valid), 64'd0);
            chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("midrst_out_pc",   bus.out_pc, 64'd0);
            mq.delete();
            @(negedge clk);
            reset_n = 1'b1;
         end
         v  = ($urandom_range(0, 9) < 7);
         r  = ($urandom_range(0, 9) < 6);
         f  = ($urandom_range(0, 31) == 0);
         pc = {$urandom, $urandom};
         w  = $urandom;
         if ($urandom_range(0, 3) == 0) w[6:0] = 7'b1101111;
         bus.in_valid  = v;
         bus.out_ready = r;
         bus.flush     = f;
         bus.in_pc     = pc;
         bus.in_ins    = w;
         acc = v && (mq.size() < DEPTH) && !f;
         pop = r && (mq.size() != 0) && !f;
         op  = w[6:0];
         fn3 = w[14:12];
         exp_redir = acc && (op == 7'b1101111);
         exp_bub   = acc && ((op == 7'b1101111) ||
                             (op == 7'b1100111 && fn3 == 3'b000) ||
                             (op == 7'b1100011 && fn3 != 3'b010 && fn3 != 3'b011));
         #1;
         chk("rnd_jal_redir", 64'(bus.jal_redir), 64'(exp_redir));
         chk("rnd_bubble",    64'(bus.bubble), 64'(exp_bub));
         if (exp_redir) chk("rnd_jal_pc", bus.jal_pc, pc + jimm(w));
         @(posedge clk);
         if (f) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{pc, w});
         end
         @(negedge clk);
      end

      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
